// File: rtl/link_pkg.sv
// Shared definitions for the inter-board player-state link.
// Packet: HEADER, B1, B2, B3, CHK with CHK = B1^B2^B3^CHK_SEED.
package link_pkg;

  localparam logic [7:0] HEADER   = 8'hA5;
  localparam logic [7:0] CHK_SEED = 8'h5A;

  typedef enum logic [2:0] {
    HUNT,
    GET_B1,
    GET_B2,
    GET_B3,
    GET_CHK
  } link_rx_state_t;

  // Field order makes {B3,B2,B1} a direct bit image of the struct
  typedef struct packed {
    logic [1:0]  level;
    logic [10:0] y;
    logic [10:0] x;
  } player_state_t;

  function automatic logic [23:0] pack_player(
    input player_state_t ps
  );
    return ps;
  endfunction

  function automatic player_state_t unpack_player(
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3
  );
    return player_state_t'({b3, b2, b1});
  endfunction

  function automatic logic [7:0] link_chk(
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3
  );
    return b1 ^ b2 ^ b3 ^ CHK_SEED;
  endfunction

endpackage

// File: rtl/link_timeout_cnt.sv
// Saturating up-counter with synchronous clear.
// done is high while the count sits at MAX.
module link_timeout_cnt #(
  parameter int unsigned MAX = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] LAST = W'(MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/player_link_rx.sv
// Receive-side decoder for the player-state link: frames 5-byte
// packets, validates the checksum, tracks liveness and errors.
module player_link_rx
  import link_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = 20000,
  parameter int unsigned LINK_TIMEOUT = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] x_value,
  output logic [11:0] y_value,
  output logic [1:0]  level,
  output logic        pkt_valid,
  output logic        link_up,
  output logic [7:0]  err_cnt
);

  link_rx_state_t state, state_nxt;
  player_state_t  ps;

  logic [7:0] b1, b2, b3;
  logic latch_b1, latch_b2, latch_b3;
  logic good, bad_pkt, gap_abort;
  logic chk_hit;
  logic gap_done, link_done;
  logic in_pkt;

  assign in_pkt  = (state != HUNT);
  assign chk_hit = (link_chk(b1, b2, b3) == rx_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // A byte arriving on the expiry cycle takes priority over the abort
  always_comb begin
    state_nxt = state;
    unique case (state)
      HUNT: begin
        if (rx_valid && rx_data == HEADER)
          state_nxt = GET_B1;
      end
      GET_B1: begin
        if (rx_valid)      state_nxt = GET_B2;
        else if (gap_done) state_nxt = HUNT;
      end
      GET_B2: begin
        if (rx_valid)      state_nxt = GET_B3;
        else if (gap_done) state_nxt = HUNT;
      end
      GET_B3: begin
        if (rx_valid)      state_nxt = GET_CHK;
        else if (gap_done) state_nxt = HUNT;
      end
      GET_CHK: begin
        if (rx_valid)      state_nxt = HUNT;
        else if (gap_done) state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    latch_b1  = 1'b0;
    latch_b2  = 1'b0;
    latch_b3  = 1'b0;
    good      = 1'b0;
    bad_pkt   = 1'b0;
    unique case (1'b1)
      (state == GET_B1): latch_b1 = rx_valid;
      (state == GET_B2): latch_b2 = rx_valid;
      (state == GET_B3): latch_b3 = rx_valid;
      (state == GET_CHK): begin
        good    = rx_valid && chk_hit;
        bad_pkt = rx_valid && !chk_hit;
      end
      default: ;
    endcase
    gap_abort = in_pkt && !rx_valid && gap_done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b1 <= '0;
      b2 <= '0;
      b3 <= '0;
    end else begin
      if (latch_b1) b1 <= rx_data;
      if (latch_b2) b2 <= rx_data;
      if (latch_b3) b3 <= rx_data;
    end
  end

  link_timeout_cnt #(.MAX(GAP_CYCLES)) u_gap (
    .clk  (clk),
    .rst  (rst),
    .clr  (rx_valid || !in_pkt),
    .en   (in_pkt),
    .done (gap_done)
  );

  link_timeout_cnt #(.MAX(LINK_TIMEOUT)) u_link (
    .clk  (clk),
    .rst  (rst),
    .clr  (good),
    .en   (1'b1),
    .done (link_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps        <= '0;
      pkt_valid <= 1'b0;
      link_up   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      pkt_valid <= good;
      if (good)
        ps <= unpack_player(b1, b2, b3);
      if (good)
        link_up <= 1'b1;
      else if (link_done)
        link_up <= 1'b0;
      if ((bad_pkt || gap_abort) && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 1'b1;
    end
  end

  assign x_value = {1'b0, ps.x};
  assign y_value = {1'b0, ps.y};
  assign level   = ps.level;

endmodule

// File: tb/tb_player_link_rx.sv
// Directed bench for player_link_rx with shortened gap/link timers.
module tb_player_link_rx;

  localparam int unsigned GAP  = 32;
  localparam int unsigned LTO  = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [11:0] x_value;
  logic [11:0] y_value;
  logic [1:0]  level;
  logic        pkt_valid;
  logic        link_up;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int base;

  player_link_rx #(
    .GAP_CYCLES   (GAP),
    .LINK_TIMEOUT (LTO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .x_value   (x_value),
    .y_value   (y_value),
    .level     (level),
    .pkt_valid (pkt_valid),
    .link_up   (link_up),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pkt_valid) pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [7:0] c);
    drive(8'hA5);
    drive(b1);
    drive(b2);
    drive(b3);
    drive(c);
  endtask

  initial begin
    step(3);
    check("rst_x", x_value, 0);
    check("rst_y", y_value, 0);
    check("rst_lvl", level, 0);
    check("rst_pv", pkt_valid, 0);
    check("rst_link", link_up, 0);
    check("rst_err", err_cnt, 0);
    rst = 1'b1;
    step(2);

    drive(8'h00);
    drive(8'hFF);
    drive(8'h3C);
    step(2);
    check("noise_err", err_cnt, 0);
    check("noise_pulses", pulses, 0);

    send(8'h2C, 8'h11, 8'h8E, 8'hE9);
    check("good_pv", pkt_valid, 1);
    check("good_x", x_value, 300);
    check("good_y", y_value, 450);
    check("good_lvl", level, 2);
    check("good_link", link_up, 1);
    check("good_err", err_cnt, 0);
    step(1);
    check("good_pv_low", pkt_valid, 0);
    check("good_pulses", pulses, 1);

    send(8'h2C, 8'h11, 8'h8E, 8'hE8);
    check("badchk_err", err_cnt, 1);
    check("badchk_pv", pkt_valid, 0);
    check("badchk_x", x_value, 300);
    step(1);
    check("badchk_pulses", pulses, 1);

    send(8'h05, 8'h38, 8'h40, 8'h27);
    check("after_bad_x", x_value, 5);
    check("after_bad_y", y_value, 7);
    check("after_bad_lvl", level, 1);

    drive(8'hA5);
    drive(8'h2C);
    step(GAP + 8);
    check("gap_err", err_cnt, 2);
    send(8'h2C, 8'h11, 8'h8E, 8'hE9);
    check("gap_next_pv", pkt_valid, 1);
    check("gap_next_x", x_value, 300);
    check("gap_next_y", y_value, 450);
    check("gap_next_err", err_cnt, 2);

    step(LTO - 20);
    check("link_still_up", link_up, 1);
    step(30);
    check("link_down", link_up, 0);
    check("hold_x", x_value, 300);
    check("hold_y", y_value, 450);
    check("hold_lvl", level, 2);

    for (int i = 0; i < 300; i++)
      send(8'h2C, 8'h11, 8'h8E, 8'hE8);
    check("sat_err", err_cnt, 8'hFF);
    check("sat_x", x_value, 300);

    drive(8'hA5);
    drive(8'h2C);
    #2;
    rst = 1'b0;
    #1;
    check("arst_x", x_value, 0);
    check("arst_y", y_value, 0);
    check("arst_lvl", level, 0);
    check("arst_err", err_cnt, 0);
    check("arst_link", link_up, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1);
    send(8'h05, 8'h38, 8'h40, 8'h27);
    check("post_rst_x", x_value, 5);
    check("post_rst_y", y_value, 7);
    check("post_rst_lvl", level, 1);
    check("post_rst_err", err_cnt, 0);
    check("post_rst_link", link_up, 1);
    step(2);

    base = pulses;
    send(8'h2C, 8'h11, 8'h8E, 8'hE9);
    check("b2b_first_pv", pkt_valid, 1);
    check("b2b_first_x", x_value, 300);
    send(8'h05, 8'h38, 8'h40, 8'h27);
    check("b2b_second_pv", pkt_valid, 1);
    check("b2b_x", x_value, 5);
    check("b2b_y", y_value, 7);
    check("b2b_lvl", level, 1);
    step(1);
    check("b2b_pulses", pulses - base, 2);
    check("b2b_err", err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
